// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty, level and underflow tracking
// for an async FIFO, clocked entirely by rclk.
module rptr_empty_ctrl #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rerr_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rerr_underflow
);

  localparam logic [ADDRSIZE:0] AE_LIM = (ADDRSIZE+1)'(AE_THRESH);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_gray;
  logic              r_empty;
  logic              r_ae;
  logic [ADDRSIZE:0] r_level;
  logic              r_err;

  logic              w_pop;
  logic [ADDRSIZE:0] w_binnext;
  logic [ADDRSIZE:0] w_graynext;
  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_levelnext;

  // Pop qualification and next pointer values
  always_comb begin
    w_pop      = rinc & ~r_empty;
    w_binnext  = r_bin + {{ADDRSIZE{1'b0}}, w_pop};
    w_graynext = (w_binnext >> 1) ^ w_binnext;
  end

  // Decode the synchronized Gray write pointer: bit i is XOR of bits MSB..i
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Occupancy seen after this edge's pop, modulo pointer range
  always_comb begin
    w_levelnext = w_wbin - w_binnext;
  end

  // Pointer, flag and level registers
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_empty <= 1'b1;
      r_ae    <= 1'b1;
      r_level <= '0;
    end else begin
      r_bin   <= w_binnext;
      r_gray  <= w_graynext;
      r_empty <= (w_graynext == rq2_wptr);
      r_ae    <= (w_levelnext <= AE_LIM);
      r_level <= w_levelnext;
    end
  end

  // Sticky underflow; a new underflow beats a simultaneous clear
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_err <= 1'b0;
    end else if (rinc && r_empty) begin
      r_err <= 1'b1;
    end else if (rerr_clr) begin
      r_err <= 1'b0;
    end
  end

  assign raddr          = r_bin[ADDRSIZE-1:0];
  assign rptr           = r_gray;
  assign rempty         = r_empty;
  assign ralmost_empty  = r_ae;
  assign rlevel         = r_level;
  assign rerr_underflow = r_err;

endmodule

// File: doc/rptr_empty_ctrl.md
Name: rptr_empty_ctrl

Overview:
Read-side pointer and status controller for the async FIFO, running entirely in the read clock domain. It consumes the write pointer after it has been synchronized into the read domain (Gray code, two-flop synchronized). It produces the RAM read address, the Gray read pointer that is sent back to the write domain, the registered empty and almost-empty flags, an occupancy count and a sticky underflow error.

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
AE_THRESH, 2, ralmost_empty asserts when occupancy <= AE_THRESH (0 .. 2^ADDRSIZE).

Ports:
rclk  input  1  read-domain clock; all state updates on posedge rclk.
rrst_n  input  1  reset, active-low, synchronous to rclk.
rinc  input  1  read request; a pop occurs on a cycle with rinc=1 and rempty=0.
rq2_wptr  input  ADDRSIZE+1  write pointer, Gray code, already synchronized into rclk.
rerr_clr  input  1  clears rerr_underflow.
raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0].
rptr  output  ADDRSIZE+1  registered Gray read pointer, for synchronization into the write domain.
rempty  output  1  registered empty flag.
ralmost_empty  output  1  registered, occupancy <= AE_THRESH.
rlevel  output  ADDRSIZE+1  registered occupancy, 0 .. 2^ADDRSIZE.
rerr_underflow  output  1  sticky: set by a read attempted while empty.

Behaviour:
- Reset: one clock, synchronous, active-low. When rrst_n=0 at a rising edge of rclk, the following values load regardless of all other inputs: rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, rerr_underflow=0.
- Pop qualify: pop = rinc & ~rempty.
- Next binary pointer: rbinnext = rbin + pop, modulo 2^(ADDRSIZE+1). The pointer wraps from all-ones to 0.
- Next Gray pointer: rgraynext = (rbinnext >> 1) ^ rbinnext.
- Pointer registers: rbin <= rbinnext and rptr <= rgraynext every cycle. rptr is driven directly from a flop, with no combinational path to the output.
- raddr is taken from the rbin register, so data for the current head is addressed in the same cycle that rinc is sampled.
- Empty flag: rempty <= (rgraynext == rq2_wptr). It is registered.
  - A pop of the last entry raises rempty on that same edge, so there is no extra cycle of false non-empty.
  - A new write pointer value clears rempty one rclk edge after rq2_wptr changes.
- Occupancy: wbin = Gray-to-binary(rq2_wptr), computed as an XOR prefix from the MSB down.
  - levelnext = wbin - rbinnext, modulo 2^(ADDRSIZE+1).
  - rlevel <= levelnext; ralmost_empty <= (levelnext <= AE_THRESH).
  - rq2_wptr may advance by several counts between samples (fast write clock); the level always follows the decoded value.
- Underflow: rinc=1 while rempty=1 means no pop; rbin and rptr hold, and rerr_underflow <= 1 on that edge.
  - rerr_clr=1 clears rerr_underflow on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Full boundary: levelnext = 2^ADDRSIZE is legal and reported as-is. Values above 2^ADDRSIZE cannot occur from a correct write side and are not checked.
- Rising edge of rq2_wptr and a pop in the same cycle: both apply, and rlevel reflects the net change.

Test Plan:
- Reset: hold rrst_n=0 for 2 cycles with rinc=1 and rq2_wptr=00111 -> rptr=00000, raddr=0, rempty=1, rlevel=0, ralmost_empty=1, rerr_underflow=0.
- Basic drain (ADDRSIZE=4, AE_THRESH=2): rq2_wptr=00010 (gray 3), rinc=0 -> next edge rempty=0, rlevel=3, ralmost_empty=0. Then rinc=1 for 3 cycles:
  - raddr=0,1,2 in those cycles;
  - rlevel 2,1,0 and ralmost_empty=1 from the first pop;
  - rempty=1 after the third edge, rptr=00010.
- Underflow: while rempty=1, rinc=1 for 1 cycle -> rerr_underflow=1 and rptr unchanged. Then rerr_clr=1 -> 0 next edge. rinc=1 and rerr_clr=1 together while empty -> rerr_underflow stays 1.
- Full depth: from reset, rq2_wptr=11000 (gray 16) -> rlevel=16, ralmost_empty=0. 16 pops -> raddr 0..15, rempty=1, rlevel=0, rptr=11000.
- Wrap-around: continue through rbin 31 -> 0 with the write side staying ahead:
  - raddr goes 15 -> 0;
  - rptr goes 10000 (gray 31) -> 00000;
  - rlevel stays correct across the wrap, with no false empty.
- Reset mid-operation: rlevel=5, rinc=1, rrst_n=0 for one edge -> all outputs at reset values next cycle. After release with rq2_wptr unchanged, rempty=0 and rlevel equals the decoded rq2_wptr.
